serial_subtractor_n: RTL and testbench

- Multi-cycle N-bit subtractor computing diff = a - b - bin (two's complement).
- Processes W bits per clock, LSB chunk first, with a registered borrow carried between chunks: a ripple-borrow chain unrolled in time.
- It is the subtract-direction counterpart to the team's N-bit ripple-carry adder.
- Used where area matters more than latency; start/busy/done handshake to a controlling FSM.

---
 rtl/serial_subtractor_n_if.sv | 52 +++++
 rtl/serial_subtractor_n.sv | 169 ++++++++++++++++
 tb/tb_serial_subtractor_n.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_n_if.sv
// rtl/serial_subtractor_n_if.sv - handshake and operand/result bundle for serial_subtractor_n
//
// Purpose: groups the start/busy/done handshake, the operands and the results
//          of the serial subtractor into one interface.
// Signals:
//   start      request from the controller
//   a, b, bin  minuend, subtrahend, borrow-in (latched by the subtractor on accept)
//   busy       operation in progress
//   done       one-cycle pulse when diff/bout/ovf become valid
//   diff       N-bit difference
//   bout       final borrow
//   ovf        signed overflow
//   zero       difference is zero (only with SERIAL_SUB_ZERO_FLAG_EN)
// Modports: master = controlling FSM, slave = subtractor.
// Optional feature macro: SERIAL_SUB_ZERO_FLAG_EN.

interface serial_subtractor_n_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
`endif
endinterface

// File: rtl/serial_subtractor_n.sv
// rtl/serial_subtractor_n.sv - multi-cycle N-bit subtractor, W bits per clock with registered borrow
//
// Purpose: computes diff = a - b - bin (two's complement) one W-bit chunk per
//          clock, LSB chunk first, carrying the borrow between chunks in a
//          register. Run length L = N/W cycles; done pulses after edge L.
// Parameters:
//   N  operand/result width
//   W  bits per cycle, must divide N
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_subtractor_n_if.slave: start/a/b/bin in, busy/done/diff/bout/ovf out
// Optional feature macro: SERIAL_SUB_ZERO_FLAG_EN adds bus.zero, a registered
//   "difference is zero" flag delivered with done and held with diff.

module serial_subtractor_n #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_subtractor_n_if.slave   bus
);

  localparam int L  = (W > 0) ? (N / W) : 1;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((W <= 0) || ((N % W) != 0)) begin : g_bad_w
      $error("serial_subtractor_n: W=%0d does not divide N=%0d", W, N);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            borrow_r, borrow_n;
  logic [N-1:0]    a_r, a_n;
  logic [N-1:0]    b_r, b_n;
  logic [N-1:0]    diff_r, diff_n;
  logic            bout_r, bout_n;
  logic            ovf_r, ovf_n;
  logic            busy_r, busy_n;
  logic            done_r, done_n;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic            nz_r, nz_n;
  logic            zero_r, zero_n;
`endif

  logic [BW-1:0]   base;
  logic [W:0]      sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      borrow_r <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      nz_r     <= 1'b0;
      zero_r   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      borrow_r <= borrow_n;
      a_r      <= a_n;
      b_r      <= b_n;
      diff_r   <= diff_n;
      bout_r   <= bout_n;
      ovf_r    <= ovf_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      nz_r     <= nz_n;
      zero_r   <= zero_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    borrow_n = borrow_r;
    a_n      = a_r;
    b_n      = b_r;
    diff_n   = diff_r;
    bout_n   = bout_r;
    ovf_n    = ovf_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    nz_n     = nz_r;
    zero_n   = zero_r;
`endif

    // Bit offset of the current chunk; always below N, so BW bits suffice.
    base = BW'(cnt) * BW'(W);
    // One W-bit slice of the borrow chain; the extra MSB is the borrow out.
    sub  = {1'b0, a_r[base +: W]} - {1'b0, b_r[base +: W]} - {{W{1'b0}}, borrow_r};

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          a_n      = bus.a;
          b_n      = bus.b;
          borrow_n = bus.bin;
          cnt_n    = '0;
          // A single-chunk run finishes on the next edge, so busy never rises.
          busy_n   = (L > 1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          nz_n     = 1'b0;
`endif
          state_n  = RUN;
        end else begin
          state_n  = IDLE;
        end
      end

      RUN: begin
        diff_n[base +: W] = sub[W-1:0];
        borrow_n          = sub[W];
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        nz_n              = nz_r | (|sub[W-1:0]);
`endif
        if (cnt == CW'(L - 1)) begin
          bout_n  = sub[W];
          // Overflow only when operand signs differ and the result sign
          // disagrees with the minuend.
          ovf_n   = (a_r[N-1] != b_r[N-1]) && (diff_n[N-1] != a_r[N-1]);
          busy_n  = 1'b0;
          done_n  = 1'b1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
          zero_n  = ~nz_n;
`endif
          state_n = DONE;
        end else begin
          cnt_n   = cnt + CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = ovf_r;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  assign bus.zero = zero_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_n.sv
// tb/tb_serial_subtractor_n.sv - self-checking bench for serial_subtractor_n (W=1 and W=4, N=8)

module tb_serial_subtractor_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic [7:0] av;
  logic [7:0] bv;
  logic       biv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_n_if #(.N(8)) bus1 ();
  serial_subtractor_n_if #(.N(8)) bus4 ();

  assign bus1.start = st;
  assign bus1.a     = av;
  assign bus1.b     = bv;
  assign bus1.bin   = biv;
  assign bus4.start = st;
  assign bus4.a     = av;
  assign bus4.b     = bv;
  assign bus4.bin   = biv;

  serial_subtractor_n #(.N(8), .W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_subtractor_n #(.N(8), .W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] d, output logic bo, output logic ov, output logic z);
    int r;
    int s;
    r  = int'(a) - int'(b) - int'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = r[7:0];
    bo = (r < 0);
    ov = (s < -128) || (s > 127);
    z  = (r[7:0] == 8'h00);
  endtask

  task automatic check_results(input string tag, input bit sel,
                               input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    check({tag, "_diff"}, sel ? bus4.diff : bus1.diff, ed);
    check({tag, "_bout"}, sel ? bus4.bout : bus1.bout, eb);
    check({tag, "_ovf"},  sel ? bus4.ovf  : bus1.ovf,  eo);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, "_zero"}, sel ? bus4.zero : bus1.zero, ez);
`else
    if (ez === 1'bx) check({tag, "_zero_model"}, 32'd0, 32'd1);
`endif
  endtask

  // One operation on the selected unit (sel=0: W=1, sel=1: W=4).
  task automatic op(input string tag, input bit sel, input logic [7:0] ea, input logic [7:0] eb, input logic ebi);
    int         l;
    int         k;
    bit         got;
    logic [7:0] ed;
    logic       ebo, eov, ez;
    l = sel ? 2 : 8;
    model(ea, eb, ebi, ed, ebo, eov, ez);
    av = ea; bv = eb; biv = ebi; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    av = 8'($urandom); bv = 8'($urandom); biv = 1'($urandom);
    k = 0; got = 0;
    while (k < 20 && !got) begin
      @(posedge clk); #1;
      k++;
      if ((sel ? bus4.done : bus1.done) === 1'b1) begin
        got = 1;
      end else begin
        check({tag, "_busy_run"}, sel ? bus4.busy : bus1.busy, 1'b1);
        if (k == 3) st = 1'b1;
        if (k == 4) st = 1'b0;
      end
    end
    check({tag, "_done_seen"}, got, 1'b1);
    check({tag, "_latency"}, k, l);
    check({tag, "_busy_at_done"}, sel ? bus4.busy : bus1.busy, 1'b0);
    check_results(tag, sel, ed, ebo, eov, ez);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, sel ? bus4.done : bus1.done, 1'b0);
    check_results({tag, "_hold"}, sel, ed, ebo, eov, ez);
  endtask

  initial begin
    logic [7:0] ea, eb, ed;
    logic       ebi, ebo, eov, ez;
    int         k;
    bit         got;

    rst = 1'b1; st = 1'b0; av = 8'h00; bv = 8'h00; biv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy1", bus1.busy, 1'b0);
    check("rst_done1", bus1.done, 1'b0);
    check("rst_diff1", bus1.diff, 8'h00);
    check("rst_bout1", bus1.bout, 1'b0);
    check("rst_ovf1",  bus1.ovf,  1'b0);
    check("rst_busy4", bus4.busy, 1'b0);
    check("rst_diff4", bus4.diff, 8'h00);

    // Directed cases, W=1.
    op("tp1", 1'b0, 8'd100, 8'd37, 1'b0);
    check("tp1_const_diff", bus1.diff, 8'h3F);
    op("tp2", 1'b0, 8'h05, 8'h0A, 1'b0);
    check("tp2_const_diff", bus1.diff, 8'hFB);
    op("tp3", 1'b0, 8'h80, 8'h01, 1'b0);
    check("tp3_const_ovf", bus1.ovf, 1'b1);
    op("tp4", 1'b0, 8'h00, 8'hFF, 1'b1);
    check("tp4_const_bout", bus1.bout, 1'b1);

    // Random cases, W=1.
    for (int i = 0; i < 12; i++)
      op("rnd1", 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));

    // Start held high: each result 9 cycles after the previous accept.
    st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ea = 8'($urandom); eb = 8'($urandom); ebi = 1'($urandom);
      model(ea, eb, ebi, ed, ebo, eov, ez);
      av = ea; bv = eb; biv = ebi;
      @(posedge clk); #1;
      av = 8'($urandom); bv = 8'($urandom); biv = 1'($urandom);
      k = 0; got = 0;
      while (k < 20 && !got) begin
        @(posedge clk); #1;
        k++;
        got = (bus1.done === 1'b1);
      end
      check("held_latency", k, 8);
      check_results("held", 1'b0, ed, ebo, eov, ez);
    end
    st = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a run.
    av = 8'h55; bv = 8'h22; biv = 1'b1; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", bus1.busy, 1'b0);
    check("midrst_done", bus1.done, 1'b0);
    check("midrst_diff", bus1.diff, 8'h00);
    check("midrst_bout", bus1.bout, 1'b0);
    check("midrst_ovf",  bus1.ovf,  1'b0);
    op("after_rst", 1'b0, 8'h10, 8'h01, 1'b0);
    check("after_rst_const", bus1.diff, 8'h0F);

    // W=4 unit.
    op("w4_eq", 1'b1, 8'h3C, 8'h3C, 1'b0);
    check("w4_eq_const", bus4.diff, 8'h00);
    op("w4_neg", 1'b1, 8'h12, 8'h34, 1'b0);
    check("w4_neg_const", bus4.diff, 8'hDE);
    for (int i = 0; i < 8; i++)
      op("rnd4", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
